// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, one-entry instruction holding register, and HALT detection.
// Latency: a fetch accepted in cycle N appears on instr/instr_valid in cycle N+1; zero-wait memory gives one instruction per cycle.
// Backpressure: stall with a valid instruction held withdraws imem_req and freezes instr/pc; branch_taken drops any response that cycle.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] instr,
  output logic [4:0]  opcode,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Fetch pointer is always halfword aligned.
  localparam logic [15:0] RESET_FPC = RESET_PC & 16'hFFFE;

  state_t      state;
  logic [15:0] fpc;
  logic        accept;
  logic        consume;

  // Request only when the holding register is free (or draining this cycle) and no redirect is pending.
  // Gating with rst_n drops the request the instant reset asserts.
  assign imem_req  = rst_n && (state == FETCH) && (!instr_valid || !stall) && !branch_taken;
  assign imem_addr = fpc;
  assign accept    = imem_req && imem_rdy;
  assign consume   = instr_valid && !stall;
  assign opcode    = instr[15:11];

  // Fetch sequencing: redirect beats fetch, fetch beats plain consumption; HALTED only drains the held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      fpc         <= RESET_FPC;
      instr       <= 16'h0000;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (state == FETCH) begin
      if (branch_taken) begin
        fpc         <= branch_target & 16'hFFFE;
        instr_valid <= 1'b0;
      end else if (accept) begin
        instr       <= imem_rdata;
        pc          <= fpc;
        instr_valid <= 1'b1;
        fpc         <= fpc + 16'd2;
        if (imem_rdata[15:11] == 5'b00000) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      end else if (consume) begin
        instr_valid <= 1'b0;
      end
    end else begin
      if (consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table for the named corner cases, then randomized traffic against a reference model.
// Latency: outputs are compared 1 time unit after the falling edge, once the inputs for that cycle are applied.
// Backpressure: stall, imem_rdy, branch_taken and reset are all randomized in the second phase.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic        instr_valid;
  logic [15:0] pc;
  logic        halted;

  int tests_run;
  int tests_failed;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdy     (imem_rdy),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic [15:0] rdata;
    logic        req;
    logic        chk_addr;
    logic [15:0] addr;
    logic        v;
    logic [15:0] pc;
    logic [15:0] ins;
    logic        h;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic rst, logic stl, logic br, logic [15:0] tgt, logic rdy,
                              logic [15:0] rdata, logic req, logic chk_addr, logic [15:0] addr,
                              logic v, logic [15:0] epc, logic [15:0] ins, logic h);
    vec_t r;
    r.rst = rst; r.stall = stl; r.br = br; r.tgt = tgt; r.rdy = rdy; r.rdata = rdata;
    r.req = req; r.chk_addr = chk_addr; r.addr = addr; r.v = v; r.pc = epc; r.ins = ins; r.h = h;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage.
  logic        m_halted;
  logic [15:0] m_fpc;
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;

  task automatic model_reset();
    m_halted = 1'b0;
    m_fpc    = 16'h0000;
    m_instr  = 16'h0000;
    m_pc     = 16'h0000;
    m_valid  = 1'b0;
  endtask

  initial begin
    bit want_req;
    bit rst_now;
    tests_run    = 0;
    tests_failed = 0;
    rst_n         = 1'b0;
    imem_rdy      = 1'b0;
    imem_rdata    = 16'h0000;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;

    // Directed sequence: each row is one cycle, starting from reset.
    tbl[0]  = mk(1,0,0,16'h0000,0,16'h0000, 0,1,16'h0000,0,16'h0000,16'h0000,0);
    tbl[1]  = mk(0,0,0,16'h0000,1,16'hC801, 1,1,16'h0000,0,16'h0000,16'h0000,0);
    tbl[2]  = mk(0,1,0,16'h0000,1,16'hFFFF, 0,0,16'h0000,1,16'h0000,16'hC801,0);
    tbl[3]  = mk(0,1,0,16'h0000,1,16'hFFFF, 0,0,16'h0000,1,16'h0000,16'hC801,0);
    tbl[4]  = mk(0,0,0,16'h0000,1,16'hC802, 1,1,16'h0002,1,16'h0000,16'hC801,0);
    tbl[5]  = mk(0,0,0,16'h0000,1,16'h4003, 1,1,16'h0004,1,16'h0002,16'hC802,0);
    tbl[6]  = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0006,1,16'h0004,16'h4003,0);
    tbl[7]  = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0006,0,16'h0004,16'h4003,0);
    tbl[8]  = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0006,0,16'h0004,16'h4003,0);
    tbl[9]  = mk(1,0,0,16'h0000,1,16'h5555, 0,1,16'h0000,0,16'h0000,16'h0000,0);
    tbl[10] = mk(0,0,0,16'h0000,1,16'hC801, 1,1,16'h0000,0,16'h0000,16'h0000,0);
    tbl[11] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0002,1,16'h0000,16'hC801,0);
    tbl[12] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0002,0,16'h0000,16'hC801,0);
    tbl[13] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0002,0,16'h0000,16'hC801,0);
    tbl[14] = mk(0,0,0,16'h0000,1,16'hC802, 1,1,16'h0002,0,16'h0000,16'hC801,0);
    tbl[15] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0004,1,16'h0002,16'hC802,0);
    tbl[16] = mk(0,0,1,16'h0041,1,16'h1234, 0,0,16'h0000,0,16'h0002,16'hC802,0);
    tbl[17] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0040,0,16'h0002,16'hC802,0);
    tbl[18] = mk(0,0,1,16'hFFFF,0,16'h0000, 0,0,16'h0000,0,16'h0002,16'hC802,0);
    tbl[19] = mk(0,0,0,16'h0000,1,16'h8888, 1,1,16'hFFFE,0,16'h0002,16'hC802,0);
    tbl[20] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0000,1,16'hFFFE,16'h8888,0);
    tbl[21] = mk(0,0,0,16'h0000,1,16'h0000, 1,1,16'h0000,0,16'hFFFE,16'h8888,0);
    tbl[22] = mk(0,0,1,16'h0100,1,16'hC801, 0,0,16'h0000,1,16'h0000,16'h0000,1);
    tbl[23] = mk(0,0,1,16'h0200,1,16'hC801, 0,0,16'h0000,0,16'h0000,16'h0000,1);
    tbl[24] = mk(0,0,0,16'h0000,1,16'hC801, 0,0,16'h0000,0,16'h0000,16'h0000,1);
    tbl[25] = mk(1,0,0,16'h0000,1,16'h7777, 0,1,16'h0000,0,16'h0000,16'h0000,0);
    tbl[26] = mk(0,0,0,16'h0000,0,16'h0000, 1,1,16'h0000,0,16'h0000,16'h0000,0);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst_n         = !tbl[i].rst;
      stall         = tbl[i].stall;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].tgt;
      imem_rdy      = tbl[i].rdy;
      imem_rdata    = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d imem_req", i), {15'd0, imem_req}, {15'd0, tbl[i].req});
      if (tbl[i].chk_addr)
        chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d instr_valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].v});
      chk($sformatf("vec%0d pc", i), pc, tbl[i].pc);
      chk($sformatf("vec%0d instr", i), instr, tbl[i].ins);
      chk($sformatf("vec%0d opcode", i), {11'd0, opcode}, {11'd0, tbl[i].ins[15:11]});
      chk($sformatf("vec%0d halted", i), {15'd0, halted}, {15'd0, tbl[i].h});
    end

    // Randomized phase against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_now = (m_halted && !m_valid && $urandom_range(3) == 0) || ($urandom_range(199) == 0);
      rst_n         = !rst_now;
      stall         = ($urandom_range(2) == 0);
      branch_taken  = ($urandom_range(7) == 0);
      branch_target = 16'($urandom);
      if ($urandom_range(15) == 0) branch_target = 16'hFFFE | 16'($urandom_range(1));
      imem_rdy      = ($urandom_range(1) == 0);
      imem_rdata    = 16'($urandom);
      if ($urandom_range(39) == 0) imem_rdata[15:11] = 5'b00000;
      #1;
      if (rst_now) model_reset();
      want_req = !rst_now && !m_halted && (!m_valid || !stall) && !branch_taken;
      chk("rnd imem_req", {15'd0, imem_req}, {15'd0, want_req});
      if (want_req) chk("rnd imem_addr", imem_addr, m_fpc);
      chk("rnd instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
      chk("rnd pc", pc, m_pc);
      chk("rnd instr", instr, m_instr);
      chk("rnd opcode", {11'd0, opcode}, {11'd0, m_instr[15:11]});
      chk("rnd halted", {15'd0, halted}, {15'd0, m_halted});
      // Advance the model to what the next rising edge should produce.
      if (!rst_now) begin
        if (!m_halted && branch_taken) begin
          m_fpc   = branch_target & 16'hFFFE;
          m_valid = 1'b0;
        end else if (want_req && imem_rdy) begin
          m_instr = imem_rdata;
          m_pc    = m_fpc;
          m_valid = 1'b1;
          m_fpc   = 16'((32'(m_fpc) + 2) % 65536);
          if (imem_rdata[15:11] == 5'b00000) m_halted = 1'b1;
        end else if (m_valid && !stall) begin
          m_valid = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
